// File: rtl/hd_frame.sv
// hd_frame: corrects pairs of Hamming(7,4) words, folds each pair into a signed value
// and accumulates a saturating per-frame sum and correction count behind a valid/ready handshake.
module hd_frame #(
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = 10,
    parameter int CNT_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [6:0]              code_word1,
    input  logic [6:0]              code_word2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0]        out_err_cnt,
    output logic                    out_sat
);
    typedef enum logic {ACC, HOLD} state_t;

    localparam logic [7:0] LEN = 8'(FRAME_LEN);

    state_t                  state;
    logic                    armed;
    logic [7:0]              cnt;
    logic                    st_v;
    logic signed [5:0]       st_r;
    logic [1:0]              st_e;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        err;
    logic                    sat;
    logic [5:0]              d1, d2;
    logic signed [5:0]       w1, w2, r;
    logic [ACC_W:0]          sum;
    logic signed [ACC_W-1:0] acc_nxt;
    logic                    ovf;
    logic [CNT_W:0]          esum;
    logic [CNT_W-1:0]        err_nxt;
    logic                    take, done;

    // Returns {syndrome nonzero, received value of the erroneous bit, corrected data}.
    function automatic logic [5:0] decode(input logic [6:0] c);
        logic [2:0] s;
        logic [6:0] e;
        s = {c[6] ^ c[3] ^ c[2] ^ c[1], c[5] ^ c[3] ^ c[2] ^ c[0], c[4] ^ c[3] ^ c[1] ^ c[0]};
        e = s == 3'b111 ? 7'b0001000 :
            s == 3'b110 ? 7'b0000100 :
            s == 3'b101 ? 7'b0000010 :
            s == 3'b011 ? 7'b0000001 :
            s == 3'b100 ? 7'b1000000 :
            s == 3'b010 ? 7'b0100000 :
            s == 3'b001 ? 7'b0010000 : 7'b0000000;
        return {|s, |(c & e), c[3:0] ^ e[3:0]};
    endfunction

    assign d1 = decode(code_word1);
    assign d2 = decode(code_word2);

    always_comb begin
        w1      = {{2{d1[3]}}, d1[3:0]};
        w2      = {{2{d2[3]}}, d2[3:0]};
        r       = {d1[4], d2[4]} == 2'b00 ? w1 + w1 + w2 :
                  {d1[4], d2[4]} == 2'b01 ? w1 + w1 - w2 :
                  {d1[4], d2[4]} == 2'b10 ? w1 - w2 - w2 : w1 + w2 + w2;
        sum     = {acc[ACC_W-1], acc} + {{(ACC_W-5){st_r[5]}}, st_r};
        ovf     = sum[ACC_W] != sum[ACC_W-1];
        acc_nxt = !ovf ? sum[ACC_W-1:0] :
                  sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        esum    = {1'b0, err} + {{(CNT_W-1){1'b0}}, st_e};
        err_nxt = esum[CNT_W] ? '1 : esum[CNT_W-1:0];
        take    = in_valid && in_ready;
        done    = st_v && cnt == LEN;
    end

    // armed keeps in_ready low until the first edge after reset release
    assign in_ready    = armed && state == ACC && cnt < LEN;
    assign out_valid   = state == HOLD;
    assign out_sum     = acc;
    assign out_err_cnt = err;
    assign out_sat     = sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            armed <= 1'b0;
            cnt   <= '0;
            st_v  <= 1'b0;
            st_r  <= '0;
            st_e  <= '0;
            acc   <= '0;
            err   <= '0;
            sat   <= 1'b0;
        end else if (clr || (state == HOLD && out_ready)) begin
            state <= ACC;
            armed <= 1'b1;
            cnt   <= '0;
            st_v  <= 1'b0;
            st_r  <= '0;
            st_e  <= '0;
            acc   <= '0;
            err   <= '0;
            sat   <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (take)
                cnt <= cnt + 8'd1;
            st_v <= take;
            st_r <= r;
            st_e <= {1'b0, d1[5]} + {1'b0, d2[5]};
            if (st_v) begin
                acc <= acc_nxt;
                err <= err_nxt;
                sat <= sat | ovf;
            end
            if (done)
                state <= HOLD;
        end
    end
endmodule

// File: tb/tb_hd_frame.sv
// tb_hd_frame: table vectors, hand sequences and random frames against a brute-force decoding model,
// run on a default-width instance and a narrow ACC_W=6 instance in lockstep.
module tb_hd_frame;
    logic clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 1;
    logic [6:0] cw1 = '0, cw2 = '0;
    logic in_ready, out_valid, out_sat;
    logic signed [9:0] out_sum;
    logic [4:0] out_err_cnt;
    logic in_ready6, out_valid6, out_sat6;
    logic signed [5:0] out_sum6;
    logic [4:0] out_err_cnt6;

    int checks = 0, errors = 0;
    logic [6:0] fa[8], fb[8];

    hd_frame dut (.clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .code_word1(cw1), .code_word2(cw2), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_err_cnt(out_err_cnt), .out_sat(out_sat));

    hd_frame #(.ACC_W(6)) dut6 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_ready(in_ready6), .code_word1(cw1), .code_word2(cw2), .out_valid(out_valid6),
        .out_ready(out_ready), .out_sum(out_sum6), .out_err_cnt(out_err_cnt6), .out_sat(out_sat6));

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] a, b;
        int sum10, err, sum6, sat6;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int synd(input logic [6:0] c);
        return int'({c[6] ^ c[3] ^ c[2] ^ c[1], c[5] ^ c[3] ^ c[2] ^ c[0], c[4] ^ c[3] ^ c[1] ^ c[0]});
    endfunction

    // The error position is whichever single bit flip turns the word into a valid codeword.
    function automatic void model_word(input logic [6:0] c, output int w, output int flag, output int e);
        int pos = -1;
        logic [6:0] t;
        if (synd(c) != 0)
            for (int i = 0; i < 7; i++) begin
                t = c ^ (7'(1) << i);
                if (synd(t) == 0) pos = i;
            end
        t = pos < 0 ? c : c ^ (7'(1) << pos);
        flag = pos < 0 ? 0 : int'(c[pos]);
        e = pos >= 0 ? 1 : 0;
        w = t[3] ? int'(t[3:0]) - 16 : int'(t[3:0]);
    endfunction

    function automatic int sat_add(input int acc, input int r, input int width, inout int sat);
        int hi = (1 << (width - 1)) - 1, lo = -(1 << (width - 1)), s = acc + r;
        if (s > hi) begin s = hi; sat = 1; end
        if (s < lo) begin s = lo; sat = 1; end
        return s;
    endfunction

    task automatic model_frame(output int s10, output int sat10, output int s6, output int sat6, output int err);
        int w1, w2, f1, f2, e1, e2, r;
        s10 = 0; sat10 = 0; s6 = 0; sat6 = 0; err = 0;
        for (int i = 0; i < 8; i++) begin
            model_word(fa[i], w1, f1, e1);
            model_word(fb[i], w2, f2, e2);
            case ({f1[0], f2[0]})
                2'b00: r = 2 * w1 + w2;
                2'b01: r = 2 * w1 - w2;
                2'b10: r = w1 - 2 * w2;
                default: r = w1 + 2 * w2;
            endcase
            s10 = sat_add(s10, r, 10, sat10);
            s6 = sat_add(s6, r, 6, sat6);
            err = err + e1 + e2 > 31 ? 31 : err + e1 + e2;
        end
    endtask

    task automatic run_frame(input string tag, input bit gaps, input int bp,
                             input int s10, input int sat10, input int s6, input int sat6, input int err);
        logic signed [9:0] held;
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 0;
                @(posedge clk); #1;
            end
            cw1 = fa[i]; cw2 = fb[i]; in_valid = 1;
            chk({tag, " in_ready"}, in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 0;
        out_ready = bp == 0;
        chk({tag, " valid_early"}, out_valid, 0);
        @(posedge clk); #1;
        chk({tag, " valid"}, out_valid, 1);
        chk({tag, " valid6"}, out_valid6, 1);
        chk({tag, " ready_hold"}, in_ready, 0);
        chk({tag, " sum"}, $signed(out_sum), s10);
        chk({tag, " sat"}, out_sat, sat10);
        chk({tag, " err"}, out_err_cnt, err);
        chk({tag, " sum6"}, $signed(out_sum6), s6);
        chk({tag, " sat6"}, out_sat6, sat6);
        held = out_sum;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk({tag, " bp_valid"}, out_valid, 1);
            chk({tag, " bp_ready"}, in_ready, 0);
            chk({tag, " bp_sum"}, $signed(out_sum), held);
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk({tag, " consumed"}, out_valid, 0);
        chk({tag, " ready_next"}, in_ready, 1);
        chk({tag, " cleared"}, $signed(out_sum), 0);
    endtask

    task automatic send_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            cw1 = 7'h63; cw2 = 7'h63; in_valid = 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " sum0"}, $signed(out_sum), 0);
        chk({tag, " err0"}, out_err_cnt, 0);
        chk({tag, " sat0"}, out_sat, 0);
        chk({tag, " valid0"}, out_valid, 0);
    endtask

    initial begin
        vec_t v[7];
        int s10, sat10, s6, sat6, err;
        v[0] = '{7'h63, 7'h63,   72, 0,  31, 1};
        v[1] = '{7'h6B, 7'h63,  -24, 8, -24, 0};
        v[2] = '{7'h23, 7'h63,   72, 8,  31, 1};
        v[3] = '{7'h00, 7'h00,    0, 0,   0, 0};
        v[4] = '{7'h7F, 7'h7F,  -24, 0, -24, 0};
        v[5] = '{7'h63, 7'h6B,   24, 8,  24, 0};
        v[6] = '{7'h78, 7'h78, -192, 0, -32, 1};

        #2;
        check_zero("reset");
        chk("reset ready", in_ready, 0);
        #10 rst_n = 1;
        #1 chk("ready_before_edge", in_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_reset", in_ready, 1);

        foreach (v[k]) begin
            for (int i = 0; i < 8; i++) begin fa[i] = v[k].a; fb[i] = v[k].b; end
            run_frame($sformatf("vec%0d", k), 0, 0, v[k].sum10, 0, v[k].sum6, v[k].sat6, v[k].err);
        end

        for (int i = 0; i < 8; i++) begin fa[i] = 7'h63; fb[i] = 7'h63; end
        run_frame("backpressure", 0, 5, 72, 0, 31, 1, 0);

        cw1 = 7'h23; cw2 = 7'h63; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        chk("parity_err_running", out_err_cnt, 1);
        chk("parity_sum_running", $signed(out_sum), 9);
        clr = 1;
        @(posedge clk); #1;
        clr = 0;

        send_pairs(3);
        in_valid = 0;
        rst_n = 0;
        #1;
        check_zero("midreset");
        chk("midreset ready", in_ready, 0);
        #2 rst_n = 1;
        @(posedge clk); #1;
        chk("midreset ready_up", in_ready, 1);
        run_frame("after_reset", 0, 0, 72, 0, 31, 1, 0);

        send_pairs(3);
        clr = 1;
        @(posedge clk); #1;
        clr = 0; in_valid = 0;
        check_zero("clr");
        chk("clr ready", in_ready, 1);
        @(posedge clk); #1;
        chk("clr stage_dropped", $signed(out_sum), 0);
        run_frame("after_clr", 0, 0, 72, 0, 31, 1, 0);

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 8; i++) begin
                fa[i] = 7'($urandom);
                fb[i] = 7'($urandom);
            end
            model_frame(s10, sat10, s6, sat6, err);
            run_frame($sformatf("rand%0d", f), 1, $urandom_range(0, 3), s10, sat10, s6, sat6, err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hd_frame.md
HD_FRAME -- requirements
Module: hd_frame

Interface
REQ-001 The parameter FRAME_LEN SHALL default to 8 and set the number of codeword pairs per frame (range 1..255).
REQ-002 The parameter ACC_W SHALL default to 10 and set the signed width of the frame accumulator (minimum 6).
REQ-003 The parameter CNT_W SHALL default to 5 and set the width of the error counter.
REQ-004 The port list SHALL be, in order:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous frame abort
- in_valid  input  1  pair valid
- in_ready  output  1  pair accepted when in_valid&in_ready
- code_word1  input  7  Hamming(7,4) word {p1,p2,p3,x1,x2,x3,x4}
- code_word2  input  7  same format
- out_valid  output  1  frame result valid
- out_ready  input  1  result consumed when out_valid&out_ready
- out_sum  output  ACC_W  signed frame sum
- out_err_cnt  output  CNT_W  codewords corrected in frame
- out_sat  output  1  accumulator saturated in frame
REQ-005 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-006 Syndrome per word: s1=b6^b3^b2^b1, s2=b5^b3^b2^b0, s3=b4^b3^b1^b0.
REQ-007 Error bit by {s1,s2,s3}: 111->b3, 110->b2, 101->b1, 011->b0, 100->b6, 010->b5, 001->b4, 000->none.
REQ-008 Per word: flag = received (uncorrected) value of the error bit, 0 if syndrome 000; w = corrected b3..b0 as signed 4-bit.
REQ-009 Pair result r (signed 6-bit) by {flag1,flag2}: 00: 2*w1+w2; 01: 2*w1-w2; 10: w1-2*w2; 11: w1+2*w2.
REQ-010 States: ACC (collecting) and HOLD (result presented); reset state ACC.
REQ-011 in_ready SHALL be 1 only in ACC while accepted-pair count < FRAME_LEN; it SHALL not depend combinationally on in_valid.
REQ-012 On accept, r and the number of nonzero syndromes (0..2) SHALL be registered into a stage register with a stage-valid bit (cycle k+1).
REQ-013 A valid stage entry SHALL add r to the accumulator with signed saturation to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on the next edge (k+2), and set the sticky sat flag when clamping occurs.
REQ-014 The error counter SHALL add the stage error count on the same edge, saturating at 2^CNT_W-1.
REQ-015 When the FRAME_LEN-th pair retires from the stage, state SHALL become HOLD, so out_valid is 1 at k+2 after the last accept.
REQ-016 In HOLD, out_sum, out_err_cnt and out_sat SHALL be stable and in_ready 0 until out_valid&out_ready.
REQ-017 On out_valid&out_ready: accumulator, counters, sat and stage cleared, state ACC; in_ready SHALL be 1 the following cycle.
REQ-018 out_sum, out_err_cnt and out_sat SHALL show running values in ACC; only out_valid qualifies them.
REQ-019 A clr asserted in any state SHALL clear all state as reset does on the next edge and SHALL override simultaneous accept, retire or output handshakes.
REQ-020 Back-to-back accepts SHALL be sustained at one pair per cycle within a frame.

Reset
REQ-021 While rst_n=0: state ACC, in_ready 0, out_valid 0, out_sum 0, out_err_cnt 0, out_sat 0, stage invalid, pair count 0.
REQ-022 in_ready SHALL rise on the first clk edge after rst_n deasserts; reset mid-frame SHALL discard all partial frame data.

Verification
REQ-023 Clean frame: 8 pairs of 7'h63/7'h63 back-to-back, out_ready=1 -> out_valid 2 cycles after the 8th accept, out_sum=72, out_err_cnt=0, out_sat=0.
REQ-024 Data-bit error: 8 pairs of 7'h6B/7'h63 -> each r=-3, out_sum=-24, out_err_cnt=8.
REQ-025 Saturation: ACC_W=6, 8 clean 7'h63 pairs -> out_sum=31, out_sat=1.
REQ-026 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid held, outputs constant, in_ready=0; first pair of the next frame accepted the cycle after out_ready rises.
REQ-027 Reset/clr mid-frame: 3 clean pairs, then rst_n=0 (repeat with clr=1) -> outputs 0; the next full clean frame gives out_sum=72, not 99.
REQ-028 Parity error: pair 7'h23/7'h63 (p1 flipped, received 0) -> flag1=0, r=9, err_cnt increments by 1.
